// File: rtl/lfsr_synapse_core_if.sv
// rtl/lfsr_synapse_core_if.sv - control/observation bundle for the LFSR synapse core
interface lfsr_synapse_core_if #(
    parameter int WIDTH = 8
);
    logic             en_i;
    logic             seed_load_i;
    logic [WIDTH-1:0] seed_i;
    logic [1:0]       mode_i;
    logic [WIDTH-1:0] q_o;
    logic             exc_o;
    logic             inh_o;
    logic [7:0]       spike_cnt_o;
    logic             lockup_o;

    modport master (
        output en_i, seed_load_i, seed_i, mode_i,
        input  q_o, exc_o, inh_o, spike_cnt_o, lockup_o
    );

    modport slave (
        input  en_i, seed_load_i, seed_i, mode_i,
        output q_o, exc_o, inh_o, spike_cnt_o, lockup_o
    );
endinterface

// File: rtl/lfsr_synapse_core.sv
// rtl/lfsr_synapse_core.sv - Fibonacci LFSR spike source with excitatory/inhibitory feedback modulation
module lfsr_synapse_core #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] TAPS    = 8'hB8,
    parameter logic [WIDTH-1:0] SEED    = 8'h01,
    parameter int               EXC_LEN = 4,
    parameter int               INH_LEN = 8,
    parameter int               CNT_W   = 4
) (
    input  logic                 clk,
    input  logic                 reset_i,
    lfsr_synapse_core_if.slave   bus
);
    localparam logic [CNT_W-1:0] EXC_INIT = CNT_W'(EXC_LEN);
    localparam logic [CNT_W-1:0] INH_INIT = CNT_W'(INH_LEN);

    logic [WIDTH-1:0] q;
    logic             prev;
    logic [CNT_W-1:0] exc_cnt;
    logic [CNT_W-1:0] inh_cnt;
    logic [7:0]       spike_cnt;
    logic             lockup;

    logic             fb;
    logic             fs;
    logic             exc_act;
    logic             inh_act;
    logic             rise;
    logic             fall;
    logic [WIDTH-1:0] load_val;

    assign exc_act  = (exc_cnt != '0);
    assign inh_act  = (inh_cnt != '0);
    assign rise     = q[0] & ~prev;
    assign fall     = ~q[0] & prev;
    assign load_val = (bus.seed_i == '0) ? SEED : bus.seed_i;
    assign fb       = ^(q & TAPS);

    // Inhibit is applied last so it overrides an excitatory flip in mode 11.
    always_comb begin
        fs = fb;
        case (bus.mode_i)
            2'b00:   fs = fb;
            2'b01:   fs = fb ^ exc_act;
            2'b10:   fs = fb & ~inh_act;
            default: fs = (fb ^ exc_act) & ~inh_act;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            q         <= SEED;
            prev      <= SEED[0];
            exc_cnt   <= '0;
            inh_cnt   <= '0;
            spike_cnt <= '0;
            lockup    <= 1'b0;
        end else begin
            // A seed load resyncs prev so the new value never counts as an edge.
            if (bus.seed_load_i) begin
                q    <= load_val;
                prev <= load_val[0];
            end else begin
                prev <= q[0];
                if (q == '0) begin
                    q <= SEED;
                end else if (bus.en_i) begin
                    q <= {q[WIDTH-2:0], fs};
                end
            end
            lockup <= ~bus.seed_load_i && (q == '0);

            if (rise) begin
                exc_cnt <= EXC_INIT;
            end else if (exc_act) begin
                exc_cnt <= exc_cnt - 1'b1;
            end

            if (fall) begin
                inh_cnt <= INH_INIT;
            end else if (inh_act) begin
                inh_cnt <= inh_cnt - 1'b1;
            end

            if (rise && spike_cnt != 8'hFF) begin
                spike_cnt <= spike_cnt + 8'd1;
            end
        end
    end

    assign bus.q_o         = q;
    assign bus.exc_o       = exc_act;
    assign bus.inh_o       = inh_act;
    assign bus.spike_cnt_o = spike_cnt;
    assign bus.lockup_o    = lockup;
endmodule

// File: tb/tb_lfsr_synapse_core.sv
// tb/tb_lfsr_synapse_core.sv - scoreboard bench for lfsr_synapse_core with directed vectors
module tb_lfsr_synapse_core;
    logic clk = 1'b0;
    logic reset_i;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    lfsr_synapse_core_if #(.WIDTH(8)) bus ();

    lfsr_synapse_core dut (
        .clk     (clk),
        .reset_i (reset_i),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // mask bits: [4] q, [3] exc, [2] inh, [1] spike count, [0] lockup
    typedef struct {
        int         cyc;
        logic [7:0] q;
        logic       exc;
        logic       inh;
        logic [7:0] cnt;
        logic       lock;
        logic [4:0] mask;
    } exp_t;

    exp_t sb[$];
    localparam logic [4:0] ALL = 5'b11111;

    task automatic check(input string name, input int tag, input logic [7:0] act, input logic [7:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s @cyc %0d: got %02h want %02h", name, tag, act, req);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                if (e.cyc != cyc) begin
                    total++;
                    bad++;
                    $display("FAIL sched: entry for cyc %0d seen at cyc %0d", e.cyc, cyc);
                end else begin
                    if (e.mask[4]) check("q_o", e.cyc, bus.q_o, e.q);
                    if (e.mask[3]) check("exc_o", e.cyc, {7'd0, bus.exc_o}, {7'd0, e.exc});
                    if (e.mask[2]) check("inh_o", e.cyc, {7'd0, bus.inh_o}, {7'd0, e.inh});
                    if (e.mask[1]) check("spike_cnt_o", e.cyc, bus.spike_cnt_o, e.cnt);
                    if (e.mask[0]) check("lockup_o", e.cyc, {7'd0, bus.lockup_o}, {7'd0, e.lock});
                end
            end
        end
    end

    task automatic step(input logic rst, input logic en, input logic ld, input logic [7:0] seed,
                        input logic [1:0] mode, input logic [7:0] q, input logic exc, input logic inh,
                        input logic [7:0] cnt, input logic lock, input logic [4:0] mask);
        exp_t e;
        reset_i         = rst;
        bus.en_i        = en;
        bus.seed_load_i = ld;
        bus.seed_i      = seed;
        bus.mode_i      = mode;
        @(posedge clk);
        #1;
        if (mask != 5'b0) begin
            e.cyc  = cyc;
            e.q    = q;
            e.exc  = exc;
            e.inh  = inh;
            e.cnt  = cnt;
            e.lock = lock;
            e.mask = mask;
            sb.push_back(e);
        end
    endtask

    initial begin
        // reset
        step(1, 1, 0, 8'h00, 2'b00, 8'h01, 0, 0, 8'd0, 0, ALL);
        step(1, 1, 0, 8'h00, 2'b00, 8'h01, 0, 0, 8'd0, 0, ALL);
        // plain Fibonacci sequence, fall at 02 and rise at 11
        step(0, 1, 0, 8'h00, 2'b00, 8'h02, 0, 0, 8'd0, 0, ALL);
        step(0, 1, 0, 8'h00, 2'b00, 8'h04, 0, 1, 8'd0, 0, ALL);
        step(0, 1, 0, 8'h00, 2'b00, 8'h08, 0, 1, 8'd0, 0, ALL);
        step(0, 1, 0, 8'h00, 2'b00, 8'h11, 0, 1, 8'd0, 0, ALL);
        step(0, 1, 0, 8'h00, 2'b00, 8'h23, 1, 1, 8'd1, 0, ALL);
        step(0, 1, 0, 8'h00, 2'b00, 8'h47, 1, 1, 8'd1, 0, ALL);
        step(0, 1, 0, 8'h00, 2'b00, 8'h8E, 1, 1, 8'd1, 0, ALL);
        step(0, 1, 0, 8'h00, 2'b00, 8'h1C, 1, 1, 8'd1, 0, ALL);
        step(0, 1, 0, 8'h00, 2'b00, 8'h38, 0, 1, 8'd1, 0, ALL);
        step(0, 1, 0, 8'h00, 2'b00, 8'h71, 0, 1, 8'd1, 0, ALL);
        step(0, 1, 0, 8'h00, 2'b00, 8'hE2, 1, 1, 8'd2, 0, ALL);
        // inhibit mode forces shifted-in bit to 0, walking into the zero state
        step(0, 1, 0, 8'h00, 2'b10, 8'hC4, 1, 1, 8'd2, 0, ALL);
        step(0, 1, 0, 8'h00, 2'b10, 8'h88, 1, 1, 8'd2, 0, ALL);
        step(0, 1, 0, 8'h00, 2'b10, 8'h10, 1, 1, 8'd2, 0, ALL);
        step(0, 1, 0, 8'h00, 2'b10, 8'h20, 0, 1, 8'd2, 0, ALL);
        step(0, 1, 0, 8'h00, 2'b10, 8'h40, 0, 1, 8'd2, 0, ALL);
        step(0, 1, 0, 8'h00, 2'b10, 8'h80, 0, 1, 8'd2, 0, ALL);
        step(0, 1, 0, 8'h00, 2'b10, 8'h00, 0, 1, 8'd2, 0, ALL);
        step(0, 1, 0, 8'h00, 2'b10, 8'h01, 0, 1, 8'd2, 1, ALL);
        step(0, 1, 0, 8'h00, 2'b10, 8'h02, 1, 0, 8'd3, 0, ALL);
        // shift disabled: q frozen, counters keep running
        step(0, 0, 0, 8'h00, 2'b00, 8'h02, 1, 1, 8'd3, 0, ALL);
        step(0, 0, 0, 8'h00, 2'b00, 8'h02, 1, 1, 8'd3, 0, ALL);
        step(0, 0, 0, 8'h00, 2'b00, 8'h02, 1, 1, 8'd3, 0, ALL);
        step(0, 0, 0, 8'h00, 2'b00, 8'h02, 0, 1, 8'd3, 0, ALL);
        // seed loads: zero seed maps to default seed, no edge produced
        step(0, 0, 1, 8'h00, 2'b00, 8'h01, 0, 1, 8'd3, 0, ALL);
        step(0, 0, 0, 8'h00, 2'b00, 8'h01, 0, 1, 8'd3, 0, ALL);
        step(0, 1, 1, 8'hA5, 2'b00, 8'hA5, 0, 1, 8'd3, 0, ALL);
        step(0, 0, 0, 8'h00, 2'b00, 8'hA5, 0, 1, 8'd3, 0, ALL);
        step(0, 1, 0, 8'h00, 2'b00, 8'h4A, 0, 0, 8'd3, 0, ALL);
        step(0, 1, 0, 8'h00, 2'b00, 8'h95, 0, 1, 8'd3, 0, ALL);
        step(0, 1, 0, 8'h00, 2'b00, 8'h2A, 1, 1, 8'd4, 0, ALL);
        // reset mid-pulse
        step(1, 1, 0, 8'h00, 2'b00, 8'h01, 0, 0, 8'd0, 0, ALL);
        // excite and excite+inhibit modes
        step(0, 1, 0, 8'h00, 2'b01, 8'h02, 0, 0, 8'd0, 0, ALL);
        step(0, 1, 0, 8'h00, 2'b01, 8'h04, 0, 1, 8'd0, 0, ALL);
        step(0, 1, 0, 8'h00, 2'b01, 8'h08, 0, 1, 8'd0, 0, ALL);
        step(0, 1, 0, 8'h00, 2'b01, 8'h11, 0, 1, 8'd0, 0, ALL);
        step(0, 1, 0, 8'h00, 2'b01, 8'h23, 1, 1, 8'd1, 0, ALL);
        step(0, 1, 0, 8'h00, 2'b01, 8'h46, 1, 1, 8'd1, 0, ALL);
        step(0, 1, 0, 8'h00, 2'b11, 8'h8C, 1, 1, 8'd1, 0, ALL);
        step(0, 1, 0, 8'h00, 2'b01, 8'h19, 1, 1, 8'd1, 0, ALL);
        step(0, 1, 0, 8'h00, 2'b00, 8'h32, 1, 1, 8'd2, 0, ALL);
        // saturation: five full periods of the maximal sequence give >255 rises
        step(1, 1, 0, 8'h00, 2'b00, 8'h01, 0, 0, 8'd0, 0, ALL);
        for (int i = 0; i < 1400; i++) begin
            step(0, 1, 0, 8'h00, 2'b00, 8'h00, 0, 0, 8'd0, 0, 5'b0);
        end
        step(0, 1, 0, 8'h00, 2'b00, 8'h00, 0, 0, 8'd255, 0, 5'b00011);
        step(0, 1, 0, 8'h00, 2'b00, 8'h00, 0, 0, 8'd255, 0, 5'b00011);

        for (int i = 0; i < 20 && sb.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (sb.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d entries left, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
